// File: rtl/prbs8_if.sv
// Bit-stream port bundle for the PRBS8 checker: qualified serial input plus
// the registered lock/error status outputs.
interface prbs8_if;
  // bit_en acts as a valid with no ready: the checker accepts bit_in on every
  // rising edge where bit_en is high and never back-pressures the source.
  logic        bit_en;
  logic        bit_in;
  logic        err_clr;
  logic        locked;
  logic        err_pulse;
  logic        period_mark;
  logic [15:0] err_count;

  modport master (
    output bit_en, bit_in, err_clr,
    input  locked, err_pulse, period_mark, err_count
  );

  modport slave (
    input  bit_en, bit_in, err_clr,
    output locked, err_pulse, period_mark, err_count
  );
endinterface

// File: rtl/prbs8_checker.sv
// Self-synchronising checker for the 0x95 PRBS8 stream: fills a history,
// hunts for a run of correct predictions, then flywheels and counts errors.
module prbs8_checker #(
  parameter int LOCK_CNT = 16,
  parameter int LOSS_CNT = 4,
  parameter int GOOD_RUN = 32
) (
  input  logic       clk,
  input  logic       reset,
  prbs8_if.slave     bus,
  output logic [1:0] dbg_state
);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);
  localparam int GW = $clog2(GOOD_RUN + 1);

  typedef enum logic [1:0] {
    S_SYNC   = 2'd0,
    S_HUNT   = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [7:0]    hist, hist_nx;   // hist[0] is the most recent accepted bit
  logic [3:0]    fill, fill_nx;
  logic [MW-1:0] match_cnt, match_nx;
  logic [LW-1:0] loss_cnt, loss_nx;
  logic [GW-1:0] good_cnt, good_nx;
  logic [15:0]   err_count_q, err_nx;
  logic          locked_q, err_pulse_q, mark_q;
  logic          err_ev, mark_ev, pred;

  assign pred            = hist[0] ^ hist[2] ^ hist[4] ^ hist[7];
  assign dbg_state       = state;
  assign bus.locked      = locked_q;
  assign bus.err_pulse   = err_pulse_q;
  assign bus.period_mark = mark_q;
  assign bus.err_count   = err_count_q;

  always_comb begin
    state_nx = state;
    hist_nx  = hist;
    fill_nx  = fill;
    match_nx = match_cnt;
    loss_nx  = loss_cnt;
    good_nx  = good_cnt;
    err_ev   = 1'b0;
    mark_ev  = 1'b0;
    if (bus.bit_en) begin
      unique case (state)
        S_SYNC: begin
          hist_nx = {hist[6:0], bus.bit_in};
          if (fill == 4'd7) begin
            state_nx = S_HUNT;
            fill_nx  = 4'd0;
            match_nx = '0;
          end else begin
            fill_nx = fill + 4'd1;
          end
        end
        S_HUNT: begin
          hist_nx = {hist[6:0], bus.bit_in};
          if (bus.bit_in == pred && hist != 8'd0) begin
            if (match_cnt == MW'(LOCK_CNT - 1)) begin
              state_nx = S_LOCKED;
              match_nx = '0;
              loss_nx  = '0;
              good_nx  = '0;
            end else begin
              match_nx = match_cnt + 1'b1;
            end
          end else begin
            match_nx = '0;
          end
        end
        S_LOCKED: begin
          // Flywheel: the history follows the prediction, so a corrupted
          // input bit never propagates into later predictions.
          hist_nx = {hist[6:0], pred};
          mark_ev = ({hist[6:0], pred} == 8'hFF);
          if (bus.bit_in != pred) begin
            err_ev  = 1'b1;
            good_nx = '0;
            if (loss_cnt == LW'(LOSS_CNT - 1)) begin
              state_nx = S_SYNC;
              fill_nx  = 4'd0;
              loss_nx  = '0;
            end else begin
              loss_nx = loss_cnt + 1'b1;
            end
          end else if (good_cnt == GW'(GOOD_RUN - 1)) begin
            good_nx = '0;
            loss_nx = '0;
          end else begin
            good_nx = good_cnt + 1'b1;
          end
        end
        default: state_nx = S_SYNC;
      endcase
    end
    err_nx = err_count_q;
    if (bus.err_clr) begin
      err_nx = {15'd0, err_ev};
    end else if (err_ev && err_count_q != 16'hFFFF) begin
      err_nx = err_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_SYNC;
      hist        <= 8'd0;
      fill        <= 4'd0;
      match_cnt   <= '0;
      loss_cnt    <= '0;
      good_cnt    <= '0;
      err_count_q <= 16'd0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      mark_q      <= 1'b0;
    end else begin
      state       <= state_nx;
      hist        <= hist_nx;
      fill        <= fill_nx;
      match_cnt   <= match_nx;
      loss_cnt    <= loss_nx;
      good_cnt    <= good_nx;
      err_count_q <= err_nx;
      locked_q    <= (state_nx == S_LOCKED);
      err_pulse_q <= err_ev;
      mark_q      <= mark_ev;
    end
  end
endmodule
